// File: rtl/mux_n_way_reg_pkg.sv
// Shared types and constants for the N-way registered select mux.
package mux_n_way_reg_pkg;

    localparam int MAX_N_INPUTS = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Select width for n sources; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_way_reg_mux_n_to_1.sv
// Combinational N:1 word select; out-of-range select yields an all-zero word.
module mux_n_to_1
    import mux_n_way_reg_pkg::*;
#(
    parameter int  WIDTH    = 32,
    parameter int  N_INPUTS = 4,
    localparam int SEL_W    = sel_width(N_INPUTS)
) (
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          data_out
);

    always_comb begin
        data_out = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (32'(sel) == k) begin
                data_out = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_n_way_reg.sv
// N-input registered select mux with a 2-entry skid and ready/valid on both sides.
// Define MUX_N_WAY_REG_SEL_ERR_EN to add the sticky sel_err output.
//
// state    | meaning
// ST_EMPTY | nothing buffered, out_valid=0, in_ready=1
// ST_ONE   | output register holds a beat, in_ready=1
// ST_TWO   | output and skid both hold beats, in_ready=0
module mux_n_way_reg
    import mux_n_way_reg_pkg::*;
#(
    parameter int  WIDTH    = 32,
    parameter int  N_INPUTS = 4,
    localparam int SEL_W    = sel_width(N_INPUTS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          select,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef MUX_N_WAY_REG_SEL_ERR_EN
    ,
    output logic                      sel_err
`endif
);

    if (N_INPUTS < 2 || N_INPUTS > MAX_N_INPUTS) begin : g_bad_n_inputs
        $error("mux_n_way_reg: N_INPUTS out of range 2..16");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_sel_q, out_sel_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic [WIDTH-1:0]   mux_data;
    logic               accept;

    mux_n_to_1 #(
        .WIDTH    (WIDTH),
        .N_INPUTS (N_INPUTS)
    ) u_mux (
        .in_data  (in_data),
        .sel      (select),
        .data_out (mux_data)
    );

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_data_d = mux_data;
                    out_sel_d  = select;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && !out_ready) begin
                    skid_data_d = mux_data;
                    skid_sel_d  = select;
                    state_d     = ST_TWO;
                end else if (accept) begin
                    out_data_d = mux_data;
                    out_sel_d  = select;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_ready) begin
                    out_data_d = skid_data_q;
                    out_sel_d  = skid_sel_q;
                    state_d    = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush drops everything in flight but leaves the last presented word visible.
        if (flush) begin
            state_d    = ST_EMPTY;
            out_data_d = out_data_q;
            out_sel_d  = out_sel_q;
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

`ifdef MUX_N_WAY_REG_SEL_ERR_EN
    logic sel_err_q, sel_err_d;

    always_comb begin
        sel_err_d = sel_err_q | (accept && (32'(select) >= N_INPUTS));
        if (flush) begin
            sel_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_n_way_reg.sv
// Directed bench for mux_n_way_reg: a 4-input instance checked against a queue model, plus a 3-input instance for range handling.
module tb_mux_n_way_reg;

    localparam int W  = 5;
    localparam int N  = 4;
    localparam int N3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [N*W-1:0] in_data;
    logic [1:0]    select;
    logic          in_valid, in_ready, flush, out_valid, out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    out_sel;

    logic [N3*W-1:0] in_data3;
    logic [1:0]    select3;
    logic          in_valid3, in_ready3, flush3, out_valid3, out_ready3;
    logic [W-1:0]  out_data3;
    logic [1:0]    out_sel3;
`ifdef MUX_N_WAY_REG_SEL_ERR_EN
    logic          sel_err, sel_err3;
`endif

    mux_n_way_reg #(.WIDTH(W), .N_INPUTS(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .select(select),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef MUX_N_WAY_REG_SEL_ERR_EN
        , .sel_err(sel_err)
`endif
    );

    mux_n_way_reg #(.WIDTH(W), .N_INPUTS(N3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .select(select3),
        .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
        .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
        .out_ready(out_ready3)
`ifdef MUX_N_WAY_REG_SEL_ERR_EN
        , .sel_err(sel_err3)
`endif
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   sel;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    rdy_ok;
    bit    acc_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_mux(input logic [N*W-1:0] d, input int s, input int n);
        if (s >= n) return '0;
        return d[s*W +: W];
    endfunction

    // Called at a negedge: compare the 4-input DUT against the model, then advance one clock.
    task automatic cyc(input string tag);
        bit    er, ev, acc, xf;
        beat_t b;
        er = rdy_ok && (sb.size() < 2);
        ev = (sb.size() > 0);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(er));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        if (ev) begin
            check({tag, ".out_data"}, 32'(out_data), 32'(sb[0].data));
            check({tag, ".out_sel"}, 32'(out_sel), 32'(sb[0].sel));
        end
        acc = in_valid && er;
        xf  = ev && out_ready;
        if (xf) void'(sb.pop_front());
        if (flush) begin
            sb.delete();
        end else if (acc) begin
            b.data = ref_mux(in_data, int'(select), N);
            b.sel  = select;
            sb.push_back(b);
        end
        rdy_ok   = 1'b1;
        acc_last = acc && !flush;
        @(negedge clk);
    endtask

    initial begin
        int idx;
        rst_n      = 1'b0;
        in_data    = {5'h1F, 5'h15, 5'h0A, 5'h00};
        select     = 2'd0;
        in_valid   = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        in_data3   = {5'h15, 5'h0A, 5'h07};
        select3    = 2'd0;
        in_valid3  = 1'b0;
        flush3     = 1'b0;
        out_ready3 = 1'b0;
        rdy_ok     = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst.out_data", 32'(out_data), 32'h0);
        check("rst.out_sel", 32'(out_sel), 32'h0);
        check("rst.out_valid", 32'(out_valid), 32'h0);
        check("rst.in_ready", 32'(in_ready), 32'h0);
        check("rst.out_valid3", 32'(out_valid3), 32'h0);
`ifdef MUX_N_WAY_REG_SEL_ERR_EN
        check("rst.sel_err", 32'(sel_err3), 32'h0);
`endif
        rst_n = 1'b1;

        // Basic single beat, select 2
        cyc("rel");
        select = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        cyc("basic.acc");
        in_valid = 1'b0;
        check("basic.data_15", 32'(out_data), 32'h15);
        cyc("basic.out");
        cyc("basic.empty");

        // Back-pressure: four beats with out_ready low for three cycles
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid  = (idx < 4);
            select    = 2'(idx);
            out_ready = (c >= 3);
            cyc("bp");
            if (acc_last) idx++;
        end
        in_valid = 1'b0;

        // Full throughput with rotating selects
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            select   = 2'(i % 4);
            cyc("thru");
        end
        in_valid = 1'b0;
        cyc("thru.drain");
        cyc("thru.idle");

        // Flush while TWO with a concurrent beat
        out_ready = 1'b0;
        in_valid = 1'b1; select = 2'd0; cyc("fl.a");
        select = 2'd1; cyc("fl.b");
        select = 2'd2; flush = 1'b1; cyc("fl.two");
        flush = 1'b0; in_valid = 1'b0; cyc("fl.after");
        // Flush beats a simultaneous accept in ONE
        in_valid = 1'b1; select = 2'd2; cyc("fl.one");
        select = 2'd3; flush = 1'b1; cyc("fl.drop");
        flush = 1'b0; in_valid = 1'b0; cyc("fl.empty");
        out_ready = 1'b1;
        in_valid = 1'b1; select = 2'd3; cyc("fl.new");
        in_valid = 1'b0; cyc("fl.new_out");
        cyc("fl.idle");

        // Out-of-range select on the 3-input instance
        select3 = 2'd3; in_valid3 = 1'b1; out_ready3 = 1'b1;
        @(negedge clk);
        in_valid3 = 1'b0; out_ready3 = 1'b0;
        check("oor.out_valid", 32'(out_valid3), 32'h1);
        check("oor.out_data", 32'(out_data3), 32'h0);
        check("oor.out_sel", 32'(out_sel3), 32'h3);
`ifdef MUX_N_WAY_REG_SEL_ERR_EN
        check("oor.sel_err", 32'(sel_err3), 32'h1);
`endif
        @(negedge clk);
        check("oor.hold_data", 32'(out_data3), 32'h0);
        check("oor.hold_valid", 32'(out_valid3), 32'h1);
        select3 = 2'd1; in_valid3 = 1'b1; out_ready3 = 1'b1;
        @(negedge clk);
        in_valid3 = 1'b0;
        check("oor.legal_data", 32'(out_data3), 32'h0A);
        check("oor.legal_sel", 32'(out_sel3), 32'h1);
`ifdef MUX_N_WAY_REG_SEL_ERR_EN
        check("oor.sticky", 32'(sel_err3), 32'h1);
`endif
        flush3 = 1'b1;
        @(negedge clk);
        flush3 = 1'b0;
        check("oor.flush_valid", 32'(out_valid3), 32'h0);
`ifdef MUX_N_WAY_REG_SEL_ERR_EN
        check("oor.flush_clr", 32'(sel_err3), 32'h0);
        select3 = 2'd3; in_valid3 = 1'b1; flush3 = 1'b1;
        @(negedge clk);
        in_valid3 = 1'b0; flush3 = 1'b0;
        check("oor.flush_wins", 32'(sel_err3), 32'h0);
        check("oor.flush_wins_valid", 32'(out_valid3), 32'h0);
`endif
        out_ready3 = 1'b0;

        // Async reset while in TWO
        out_ready = 1'b0;
        in_valid = 1'b1; select = 2'd1; cyc("ar.a");
        select = 2'd2; cyc("ar.b");
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.out_valid", 32'(out_valid), 32'h0);
        check("ar.in_ready", 32'(in_ready), 32'h0);
        check("ar.out_data", 32'(out_data), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        rdy_ok = 1'b0;
        in_valid = 1'b0;
        cyc("ar.rel");
        out_ready = 1'b1;
        in_valid = 1'b1; select = 2'd3; cyc("ar.acc");
        in_valid = 1'b0; cyc("ar.out");
        cyc("ar.idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_n_way_reg.md
Name: mux_n_way_reg

Overview:
Parametrised successor to the fixed-width 2:1 datapath muxes. It is an N-input, WIDTH-bit select mux with a registered output stage and a ready/valid handshake on both sides.
- A 2-entry skid buffer gives full throughput under downstream back-pressure.
- Sits between pipeline stages, e.g. the forwarding/writeback source select feeding the next stage register.
- Supports pipeline flush.

Parameters:
WIDTH, 32, data width of each input and of the output
N_INPUTS, 4, number of selectable sources, legal range 2..16
SEL_W, $clog2(N_INPUTS), select width; derived localparam, not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  N_INPUTS*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH]
select  input  SEL_W  source index, sampled with the beat
in_valid  input  1  upstream beat valid
in_ready  output  1  block can accept a beat this cycle
flush  input  1  synchronous clear of all buffered beats
out_data  output  WIDTH  registered selected data
out_sel  output  SEL_W  select value that produced out_data
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data this cycle

Interface: one clock (clk); reset is asynchronous and active-low (rst_n).

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_data=0, out_sel=0, out_valid=0; skid entry cleared.
  - in_ready=0 while rst_n is low; in_ready=1 in the first cycle after release.
- Accept: a beat is accepted when in_valid && in_ready at a clk edge. Mux result = in_data[select*WIDTH +: WIDTH].
- Out-of-range select (select >= N_INPUTS, only possible when N_INPUTS is not a power of 2): muxed data is all zeros. The beat is still accepted and out_sel carries the raw select value.
- Latency: 1 cycle. A beat accepted at edge t appears at out_data/out_valid after edge t.
- Output transfer: occurs when out_valid && out_ready.
- State machine (registered):
  - EMPTY: out_valid=0, in_ready=1.
    - Accept -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept && !out_ready -> TWO; new beat goes to the skid entry.
    - Accept && out_ready -> ONE; new beat replaces the output register.
    - No accept && out_ready -> EMPTY.
  - TWO: out_valid=1, in_ready=0.
    - out_ready -> ONE; skid entry moves to the output register next cycle.
- in_ready is a registered function of state, never combinational from out_ready.
- Beats leave in acceptance order. No beat is duplicated or dropped except by flush.
- Flush:
  - Next state is EMPTY and out_valid=0 after the edge; out_data/out_sel hold their last values.
  - Flush overrides a simultaneous accept (the beat is dropped) and a simultaneous output transfer (that transfer still counts as completed downstream).
- Held inputs: while out_valid=1 and out_ready=0, out_data and out_sel are stable.
- Upstream obligation: no combinational dependence of in_valid on in_ready is required.

Optional Feature:
MUX_N_WAY_REG_SEL_ERR_EN
- Defined:
  - Adds output port sel_err (1 bit), reset 0.
  - sel_err is set sticky at the edge that accepts a beat with select >= N_INPUTS.
  - sel_err is cleared by flush. If flush and an erroneous accept coincide, flush wins and sel_err=0.
- Undefined: port absent, no range-check logic. Datapath behaviour is identical in both cases.

Decomposition:
- Shared include mux_defs.vh:
  - State encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - Macro for the clog2-based select width.
  - MAX_N_INPUTS=16 guard constant.
- One natural combinational sub-module, mux_n_to_1 (WIDTH, N_INPUTS), producing the zero-default selected word. Instantiated once, ahead of the skid/output registers.

Test Plan:
1. Reset/basic: WIDTH=5, N_INPUTS=4, in_data={5'h1F,5'h15,5'h0A,5'h00}, select=2, single in_valid pulse, out_ready=1 -> out_data=5'h15 and out_sel=2 one cycle later, out_valid high for exactly 1 cycle. All outputs 0 while rst_n=0.
2. Back-pressure: stream selects 0,1,2,3 back-to-back with out_ready=0 for 3 cycles:
   - in_ready drops after 2 accepts.
   - out_data holds 5'h00.
   - On out_ready=1, the sequence 00,0A,15,1F emerges in order with no loss.
3. Full throughput: out_ready=1, in_valid=1 for 20 cycles with rotating selects -> 20 outputs in consecutive cycles, in_ready never low.
4. Flush: with state TWO, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and the flushed and concurrent beats never appear.
5. Out-of-range: N_INPUTS=3, select=3 -> out_data=0, out_sel=3. With MUX_N_WAY_REG_SEL_ERR_EN, sel_err=1 until flush.
6. Async reset mid-stream: drop rst_n between edges while in TWO -> out_valid=0 immediately without a clock edge. After release, in_ready=1 and the first new beat passes with 1-cycle latency.
